// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame controller: counts qualified LSB-first bits into a shift
// register and hands each complete word to a one-deep valid/ready holding register.
module sipo_frame_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       din,
  input  logic                       din_valid,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       overrun,
  input  logic                       clear_ovr
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] word_next;
  logic             complete;
  logic             handshake;
  logic             load;

  always_comb begin
    word_next = {din, sr[WIDTH-1:1]};
    // start outranks a completing bit, so the frame is discarded instead of delivered
    complete  = (state == StShift) && din_valid && !start && (bit_cnt == CntW'(WIDTH - 1));
    handshake = dout_valid && dout_ready;
    load      = complete && (!dout_valid || handshake);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      sr         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      bit_cnt    <= '0;
      overrun    <= 1'b0;
    end else begin
      if (handshake) begin
        dout_valid <= 1'b0;
      end
      if (load) begin
        dout       <= word_next;
        dout_valid <= 1'b1;
      end

      // A drop in the same cycle as a clear leaves the flag set
      if (clear_ovr) begin
        overrun <= 1'b0;
      end
      if (complete && !load) begin
        overrun <= 1'b1;
      end

      unique case (state)
        StIdle: begin
          if (start) begin
            state   <= StShift;
            busy    <= 1'b1;
            bit_cnt <= '0;
          end
        end
        StShift: begin
          if (start) begin
            bit_cnt <= '0;
          end else if (din_valid) begin
            sr <= word_next;
            if (complete) begin
              state   <= StIdle;
              busy    <= 1'b0;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CntW'(1);
            end
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Scoreboard bench for sipo_frame_ctrl: a transaction-level model collects bits in a queue,
// queues delivered words, and a negedge monitor compares outputs and handshaked words.
module tb_sipo_frame_ctrl;

  localparam int unsigned W = 8;
  localparam int unsigned CntW = $clog2(W + 1);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            din = 1'b0;
  logic            din_valid = 1'b0;
  logic [W-1:0]    dout;
  logic            dout_valid;
  logic            dout_ready = 1'b0;
  logic            busy;
  logic [CntW-1:0] bit_cnt;
  logic            overrun;
  logic            clear_ovr = 1'b0;

  sipo_frame_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .busy      (busy),
    .bit_cnt   (bit_cnt),
    .overrun   (overrun),
    .clear_ovr (clear_ovr)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit           armed = 1'b0;
  bit           in_frame = 1'b0;
  bit           held = 1'b0;
  bit           ovr = 1'b0;
  logic [W-1:0] mdout = '0;
  bit           bits[$];
  logic [W-1:0] exp_q[$];

  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clk) begin
    bit           hs;
    bit           done;
    bit           load_ok;
    logic [W-1:0] w;
    if (reset) begin
      armed    = 1'b1;
      in_frame = 1'b0;
      held     = 1'b0;
      ovr      = 1'b0;
      mdout    = '0;
      bits.delete();
      exp_q.delete();
    end else begin
      hs   = held && dout_ready;
      done = 1'b0;
      w    = '0;
      if (start) begin
        in_frame = 1'b1;
        bits.delete();
      end else if (in_frame && din_valid) begin
        bits.push_back(din);
        if (bits.size() == W) begin
          for (int i = 0; i < W; i++) w = w | (W'(bits[i]) << i);
          done     = 1'b1;
          in_frame = 1'b0;
          bits.delete();
        end
      end
      load_ok = !held || hs;
      if (hs) held = 1'b0;
      if (clear_ovr) ovr = 1'b0;
      if (done) begin
        if (load_ok) begin
          held  = 1'b1;
          mdout = w;
          exp_q.push_back(w);
        end else begin
          ovr = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: per-cycle output checks plus scoreboard pop on every handshake
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (armed) begin
      check("dout_valid", 32'(dout_valid), 32'(held));
      check("overrun", 32'(overrun), 32'(ovr));
      check("busy", 32'(busy), 32'(in_frame));
      check("bit_cnt", 32'(bit_cnt), 32'(bits.size()));
      check("dout", 32'(dout), 32'(mdout));
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(dout), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("word", 32'(dout), 32'(e));
        end
      end
    end
  end

  task automatic drive(input logic s, input logic dv, input logic d, input logic rdy,
                       input logic clr);
    start = s; din_valid = dv; din = d; dout_ready = rdy; clear_ovr = clr;
    @(posedge clk);
    #1;
  endtask

  // start (with a junk din_valid bit that must be discarded), then W bits with random gaps
  task automatic send_word(input logic [W-1:0] w, input int gap_max, input logic rdy,
                           input logic last_rdy);
    drive(1'b1, 1'($urandom), 1'($urandom), rdy, 1'b0);
    for (int i = 0; i < W; i++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int k = 0; k < g; k++) drive(1'b0, 1'b0, 1'($urandom), rdy, 1'b0);
      drive(1'b0, 1'b1, w[i], (i == W - 1) ? last_rdy : rdy, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);  // din_valid in IDLE is ignored

    send_word(8'hA5, 0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'hA5, 3, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure and overrun
    send_word(8'h3C, 0, 1'b0, 1'b0);
    send_word(8'hC3, 1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load coincident with handshake
    send_word(8'h11, 0, 1'b0, 1'b0);
    send_word(8'h22, 0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Restart after 5 bits
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    send_word(8'hF0, 0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Restart on the completing cycle
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < W - 1; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    send_word(8'h96, 0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-frame with a word held and overrun set
    send_word(8'h77, 0, 1'b0, 1'b0);
    send_word(8'h78, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    send_word(8'h5A, 0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(499, 0) == 0);
      drive(($urandom_range(29, 0) == 0), ($urandom_range(9, 0) < 7), 1'($urandom),
            ($urandom_range(3, 0) != 0), ($urandom_range(19, 0) == 0));
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
